// File: rtl/seq_divider_if.sv
// Handshake and operand bundle for seq_divider: the master issues start/operands
// and the slave returns busy/done/err with the quotient and remainder.
interface seq_divider_if #(
   parameter int bw = 16
);
   logic              start;
   logic [2*bw-1:0]   dividend;
   logic [bw-1:0]     divisor;
   logic              busy;
   logic              done;
   logic              err;
   logic [bw-1:0]     quotient;
   logic [bw-1:0]     remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, err, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, err, quotient, remainder
   );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider: 2*bw-bit dividend by bw-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_BYPASS_EN finishes a divide-by-one in a single cycle.
module seq_divider #(
   parameter int bw = 16
) (
   input  logic         CLK,
   input  logic         RESETn,
   seq_divider_if.slave bus
);
   localparam int            CW   = $clog2(bw);
   localparam int            TW   = bw + 2;
   localparam logic [CW-1:0] LAST = CW'(bw - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_ERR} state_e;

   state_e        state_q, state_d;
   logic [bw-1:0] d_q, d_d;
   logic [bw:0]   r_q, r_d;
   logic [bw-1:0] q_q, q_d;
   logic [CW-1:0] count_q, count_d;
   logic [bw-1:0] quotient_q, quotient_d;
   logic [bw-1:0] remainder_q, remainder_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [bw:0]   shifted;
   logic [bw:0]   trial;
   logic          carry;
   logic          no_borrow;
   logic          load_err;
   logic          bypass;

   assign shifted = {r_q[bw-1:0], q_q[bw-1]};

   // Trial subtract as shifted + ~D + 1; the carry out is the "no borrow" flag.
   assign {carry, trial} = {1'b0, shifted} + {2'b01, ~d_q} + TW'(1);
   assign no_borrow      = carry | r_q[bw];

   assign load_err = (bus.divisor == '0) || (bus.dividend[2*bw-1:bw] >= bus.divisor);

`ifdef SEQ_DIVIDER_BYPASS_EN
   assign bypass = (bus.divisor == bw'(1));
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      state_d     = state_q;
      d_d         = d_q;
      r_d         = r_q;
      q_d         = q_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      err_d       = err_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               d_d     = bus.divisor;
               r_d     = {1'b0, bus.dividend[2*bw-1:bw]};
               q_d     = bus.dividend[bw-1:0];
               count_d = '0;
               // A divide-by-one has Q = low half and R = 0 already, so FIN can publish it.
               if (load_err)    state_d = S_ERR;
               else if (bypass) state_d = S_FIN;
               else             state_d = S_RUN;
            end
         end
         S_RUN: begin
            r_d     = no_borrow ? trial : shifted;
            q_d     = {q_q[bw-2:0], no_borrow};
            count_d = count_q + CW'(1);
            if (count_q == LAST) state_d = S_FIN;
         end
         S_FIN: begin
            quotient_d  = q_q;
            remainder_d = r_q[bw-1:0];
            err_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
         S_ERR: begin
            quotient_d  = '1;
            remainder_d = '0;
            err_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= S_IDLE;
         d_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         r_q         <= r_d;
         q_q         <= q_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // The done cycle is spent in IDLE, so busy and done can never overlap.
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
endmodule
